// File: rtl/req_encoder_4x2_if.sv
// Handshake and request bundle for the 4-to-2 request encoder.
// The slave side is the encoder. The master side is whoever drives the
// request lines and consumes the grant (decoder select path or a bench).
`timescale 1ns/1ps

interface req_encoder_4x2_if;
    logic       in0;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       ack;
    logic       clr_overrun;
    logic [1:0] sel;
    logic       valid;
    logic       multi;
    logic       overrun;
    logic [3:0] pending;

    modport slave (
        input  in0,
        input  in1,
        input  in2,
        input  in3,
        input  ack,
        input  clr_overrun,
        output sel,
        output valid,
        output multi,
        output overrun,
        output pending
    );

    modport master (
        output in0,
        output in1,
        output in2,
        output in3,
        output ack,
        output clr_overrun,
        input  sel,
        input  valid,
        input  multi,
        input  overrun,
        input  pending
    );
endinterface

// File: rtl/req_encoder_4x2.sv
// Sequential 4-to-2 request encoder.
// Rising edges on four request lines are latched as pending requests.
// Pending requests are arbitrated round-robin and offered one at a time as a
// 2-bit index on a valid/ack handshake. Every output is registered.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no offer; picks the next pending request in search order
// ST_OFFER | sel/multi held, valid=1, waiting for ack
`timescale 1ns/1ps

module req_encoder_4x2 (
    input  logic              clock,
    input  logic              reset_n,
    req_encoder_4x2_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t     state_q, state_d;

    logic [3:0] req_lines;
    logic [3:0] in_q;
    logic [3:0] rise;

    logic [3:0] pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic [1:0] sel_q, sel_d;
    logic       multi_q, multi_d;
    logic       valid_q, valid_d;
    logic [1:0] last_q, last_d;

    logic       accept;
    logic [3:0] ack_clr;
    logic [3:0] overrun_hit;

    logic [1:0] pick_idx;
    logic       pick_found;
    logic [1:0] cand;
    logic       many;

    assign req_lines = {bus.in3, bus.in2, bus.in1, bus.in0};
    assign rise      = req_lines & ~in_q;

    // An ack is only meaningful while an offer is on the bus.
    assign accept  = (state_q == ST_OFFER) && bus.ack;
    assign ack_clr = accept ? (4'b0001 << sel_q) : 4'b0000;

    // A rise on a line that is already pending is merged and flagged. The bit
    // being acked this cycle is excluded: that rise is a fresh request.
    assign overrun_hit = rise & pending_q & ~ack_clr;

    // More than one bit set: clearing the lowest set bit leaves something.
    assign many = |(pending_q & (pending_q - 4'd1));

    // Edge-detect history of the request lines.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= 4'b0000;
        end else begin
            in_q <= req_lines;
        end
    end

    // Pending vector and sticky overrun: new rises beat same-cycle clears.
    always_comb begin
        pending_d = (pending_q & ~ack_clr) | rise;
        overrun_d = overrun_q;
        if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (|overrun_hit) begin
            overrun_d = 1'b1;
        end
    end

    // Round-robin pick from the registered pending vector, starting after last.
    always_comb begin
        pick_idx   = 2'd0;
        pick_found = 1'b0;
        cand       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!pick_found && pending_q[cand]) begin
                pick_idx   = cand;
                pick_found = 1'b1;
            end
        end
    end

    // FSM next-state and registered-output next values.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        multi_d = multi_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (pick_found) begin
                    sel_d   = pick_idx;
                    multi_d = many;
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (bus.ack) begin
                    last_d  = sel_q;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; last resets to 3 so the first search starts at 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pending_q <= 4'b0000;
            overrun_q <= 1'b0;
            sel_q     <= 2'd0;
            multi_q   <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 2'd3;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            sel_q     <= sel_d;
            multi_q   <= multi_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.valid   = valid_q;
    assign bus.multi   = multi_q;
    assign bus.overrun = overrun_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_req_encoder_4x2.sv
// Directed bench for req_encoder_4x2: a per-cycle vector table plus
// hand-written sequences for reset, stall and fairness.
`timescale 1ns/1ps

module tb_req_encoder_4x2;

    logic clock;
    logic reset_n;

    req_encoder_4x2_if bus ();

    req_encoder_4x2 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic       clr;
        logic [3:0] p;
        logic       v;
        logic [1:0] s;
        logic       m;
        logic       o;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic a, input logic c);
        bus.in0         = r[0];
        bus.in1         = r[1];
        bus.in2         = r[2];
        bus.in3         = r[3];
        bus.ack         = a;
        bus.clr_overrun = c;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_offer(input string name, input logic [1:0] exp_sel, input logic exp_multi);
        for (int n = 0; n < 20 && bus.valid !== 1'b1; n++) step();
        chk({name, " valid"}, {7'd0, bus.valid}, 8'd1);
        chk({name, " sel"},   {6'd0, bus.sel},   {6'd0, exp_sel});
        chk({name, " multi"}, {7'd0, bus.multi}, {7'd0, exp_multi});
    endtask

    task automatic do_ack(input string name);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk({name, " valid after ack"}, {7'd0, bus.valid}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // req    ack   clr   p        v     s      m     o
        vecs[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{4'b1111, 1'b1, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1110, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[4]  = '{4'b1111, 1'b1, 1'b0, 4'b1110, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[5]  = '{4'b1111, 1'b1, 1'b0, 4'b1100, 1'b0, 2'd1, 1'b1, 1'b0};
        vecs[6]  = '{4'b1111, 1'b1, 1'b0, 4'b1100, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[7]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b0, 2'd2, 1'b1, 1'b0};
        vecs[8]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0};
        vecs[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
        vecs[10] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
        vecs[11] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd3, 1'b0, 1'b0};
        vecs[12] = '{4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[13] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1};
        vecs[14] = '{4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1};
        vecs[15] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1};
        vecs[16] = '{4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[17] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[18] = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[19] = '{4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[20] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[21] = '{4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[22] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[23] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[24] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};

        // Reset held while every input toggles: outputs must stay at zero.
        reset_n = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
            chk($sformatf("reset%0d outputs", i),
                {bus.pending, bus.sel, bus.valid, bus.multi},  8'd0);
            chk($sformatf("reset%0d overrun", i), {7'd0, bus.overrun}, 8'd0);
        end

        // Release, pulse in2: offer appears two edges after the pulse edge.
        drive(4'b0000, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(4'b0100, 1'b0, 1'b0);
        step();
        chk("pulse E1 pending", {4'd0, bus.pending}, 8'h04);
        chk("pulse E1 valid",   {7'd0, bus.valid},   8'd0);
        drive(4'b0000, 1'b0, 1'b0);
        step();
        chk("pulse E2 valid", {7'd0, bus.valid}, 8'd1);
        chk("pulse E2 sel",   {6'd0, bus.sel},   8'd2);
        chk("pulse E2 multi", {7'd0, bus.multi}, 8'd0);

        // Reset mid-offer drops valid without waiting for a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset valid",   {7'd0, bus.valid},   8'd0);
        chk("async reset pending", {4'd0, bus.pending}, 8'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Per-cycle vector table from a fresh reset.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].req, vecs[i].ack, vecs[i].clr);
            step();
            chk($sformatf("vec%0d pending", i), {4'd0, bus.pending}, {4'd0, vecs[i].p});
            chk($sformatf("vec%0d valid", i),   {7'd0, bus.valid},   {7'd0, vecs[i].v});
            chk($sformatf("vec%0d sel", i),     {6'd0, bus.sel},     {6'd0, vecs[i].s});
            chk($sformatf("vec%0d multi", i),   {7'd0, bus.multi},   {7'd0, vecs[i].m});
            chk($sformatf("vec%0d overrun", i), {7'd0, bus.overrun}, {7'd0, vecs[i].o});
        end

        // Stall: offer of 0 held while in1 and in3 rise.
        for (int c = 0; c < 10; c++) begin
            drive({(c >= 4) ? 1'b1 : 1'b0, 1'b0, (c >= 2) ? 1'b1 : 1'b0, 1'b1}, 1'b0, 1'b0);
            step();
            chk($sformatf("stall%0d valid", c), {7'd0, bus.valid}, 8'd1);
            chk($sformatf("stall%0d sel", c),   {6'd0, bus.sel},   8'd0);
            chk($sformatf("stall%0d multi", c), {7'd0, bus.multi}, 8'd0);
        end
        chk("stall pending", {4'd0, bus.pending}, 8'h0B);
        chk("stall overrun", {7'd0, bus.overrun}, 8'd0);
        do_ack("stall ack0");
        chk("stall pending after ack", {4'd0, bus.pending}, 8'h0A);
        wait_offer("stall next1", 2'd1, 1'b1);
        do_ack("stall ack1");
        wait_offer("stall next3", 2'd3, 1'b0);
        do_ack("stall ack3");
        chk("stall pending drained", {4'd0, bus.pending}, 8'h00);

        // Fairness after wrap: 1 and 3 held, 1 re-raised -> 1,3,1.
        drive(4'b0000, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        @(negedge clock);
        reset_n = 1'b1;
        drive(4'b1010, 1'b0, 1'b0);
        wait_offer("fair g1", 2'd1, 1'b1);
        bus.in1 = 1'b0;
        do_ack("fair g1");
        wait_offer("fair g3", 2'd3, 1'b0);
        bus.in1 = 1'b1;
        do_ack("fair g3");
        wait_offer("fair g1b", 2'd1, 1'b0);
        do_ack("fair g1b");
        chk("fair pending", {4'd0, bus.pending}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_encoder_4x2.md
# req_encoder_4x2

Sequential 4-to-2 request encoder: the inverse of the team's 2-to-4 one-hot output decoder. It watches four single-bit request lines, latches rising edges as pending requests, and arbitrates them round-robin. It presents one 2-bit index at a time on a valid/ack handshake, so a downstream consumer (typically the decoder select path) services each request exactly once.

## Interface
- No parameters. Request count is fixed at 4 and index width at 2.
- `clock` in 1: single system clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in0`, `in1`, `in2`, `in3` in 1 each: request lines, level signals synchronous to `clock`. A request is a 0→1 transition.
- `sel` out 2: index of the granted request; valid only while `valid`=1.
- `valid` out 1: grant offer is present.
- `ack` in 1: consumer accepts the offer. Sampled only while `valid`=1.
- `multi` out 1: more than one request was pending when the current `sel` was chosen.
- `overrun` out 1: sticky flag. A rising edge arrived on a line whose request was already pending.
- `clr_overrun` in 1: synchronous clear of `overrun`.
- `pending` out 4: current pending-request vector, bit i for `in<i>`.

## Operation
- Edge detect: register `in_q[3:0]`. `rise[i] = in<i> & ~in_q[i]`.
- Pending set: on `rise[i]`, `pending[i]` is set to 1.
- Overrun: if `rise[i]` occurs while `pending[i]` is already 1, the request is merged (no second pending) and `overrun` is set to 1.
- `clr_overrun` clears `overrun`. If `clr_overrun` and a new overrun occur in the same cycle, the set wins.
- Priority pointer `last[1:0]`. The search order is `last+1`, `last+2`, `last+3`, `last` (mod 4, wrap 3→0).
- FSM states:
  - IDLE: `valid`=0. If `pending` is nonzero, load `sel` with the first set bit in search order, load `multi` = (popcount(`pending`) > 1), set `valid`=1, and go to OFFER. Otherwise stay.
  - OFFER: `sel`, `multi` and `valid` are held stable. When `ack`=1, clear `pending[sel]`, set `last`=`sel`, set `valid`=0, and go to IDLE. When `ack`=0, stay.
- Arbitration uses the registered `pending` value, not the same-cycle `rise`.
- Simultaneous `ack` and `rise[sel]` in one cycle: the set wins. `pending[sel]` stays 1, `overrun` is not set, and the line is served again later.
- `rise` on other lines during OFFER: the corresponding pending bits are set normally. They do not affect the current `sel`.
- `ack` while in IDLE is ignored.

## Timing
- Reset values (asynchronous, immediate on `reset_n`=0):
  - `sel`=0, `valid`=0, `multi`=0, `overrun`=0, `pending`=0
  - `in_q`=0, `last`=3 (first search starts at index 0), state=IDLE
- Reset mid-offer: the offer is dropped immediately and all pending requests are lost.
- Release: all state holds reset values until the first rising edge with `reset_n`=1.
- Lines already high when reset releases produce a `rise` on the first clock edge after release, because `in_q`=0.
- Latency: `in<k>` rises before edge E1, so `pending[k]`=1 after E1 and `valid`=1 / `sel`=k after E2.
- With `ack`=1 at edge E3, `valid`=0 after E3. The next grant can be valid after E4.
- Throughput: at most one grant per 2 cycles, because of the mandatory IDLE bubble.
- While `valid`=1, `sel` and `multi` change only through reset.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- Reset: assert `reset_n`=0 with all inputs toggling -> all outputs 0. Release, pulse `in2` -> `sel`=2 and `valid`=1 two edges after the pulse edge, `multi`=0.
- Round-robin order: raise `in0`..`in3` in the same cycle, ack each offer immediately -> `sel` sequence 0,1,2,3, `multi`=1,1,1,0, final `pending`=0.
- Fairness after wrap: `last`=3. Hold requests 1 and 3, ack, then re-raise 1 -> grants 1,3,1. Index 3 is never starved.
- Stall: hold `ack`=0 for 10 cycles while `in1`, `in3` rise -> `sel` and `multi` stay constant, `pending`=4'b1010 plus the offered bit. After `ack`, the next offer follows in search order.
- Overrun: two rising edges on `in0` before ack -> one grant, `overrun`=1 until `clr_overrun`. Simultaneous `clr_overrun` and a new overrun -> `overrun` stays 1.
- Collision: `rise` on `in<sel>` in the `ack` cycle -> `pending[sel]` stays 1, `overrun`=0, and the same index is re-offered later. Apply `reset_n`=0 during OFFER -> `valid` drops asynchronously.
